// File: rtl/reset_sequencer.sv
// Staged reset sequencer: filters PLL lock, then releases NUM_STAGES active-high resets in order.
// Optional watchdog on time spent in HOLD is enabled by defining RESET_SEQ_WDOG_EN.
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_FILTER = 8,
  parameter int SOFT_HOLD   = 32,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  soft_rst_i,
  output logic [NUM_STAGES-1:0] rst_stage_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int LW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(SOFT_HOLD + 1);
  localparam int DW = $clog2(STAGE_DELAY + 1);
  localparam int IW = $clog2(NUM_STAGES + 1);

  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_FILTER);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(SOFT_HOLD);
  localparam logic [DW-1:0] DLY_LAST  = DW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_e;

  state_e                  state_q, state_d;
  logic                    lock_meta, lock_s;
  logic [LW-1:0]           lock_cnt_q, lock_cnt_d;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic [DW-1:0]           dly_cnt_q, dly_cnt_d;
  logic [IW-1:0]           stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample together, forming a real 2-stage shift.
      lock_meta <= pll_locked_i;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HOLD;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      dly_cnt_q   <= '0;
      stage_idx_q <= '0;
      stage_q     <= '1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      stage_idx_q <= stage_idx_d;
      stage_q     <= stage_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    stage_idx_d = stage_idx_q;
    stage_d     = stage_q;
    done_d      = done_q;

    unique case (state_q)
      HOLD: begin
        stage_d     = '1;
        done_d      = 1'b0;
        dly_cnt_d   = '0;
        stage_idx_d = '0;
        if (!lock_s)                  lock_cnt_d = '0;
        else if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
        if (soft_rst_i)               hold_cnt_d = HOLD_MAX;
        else if (hold_cnt_q != '0)    hold_cnt_d = hold_cnt_q - 1'b1;
        if (!soft_rst_i && lock_cnt_d == LOCK_MAX && hold_cnt_q == '0)
          state_d = RELEASE;
      end
      RELEASE: begin
        if (stage_idx_q == IDX_LAST) begin
          state_d = RUN;
          done_d  = 1'b1;
        end else if (dly_cnt_q == DLY_LAST) begin
          // Shifting in zeros from the bottom releases bit 0 first and never re-asserts a bit.
          dly_cnt_d   = '0;
          stage_d     = stage_q << 1;
          stage_idx_d = stage_idx_q + 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      RUN: begin
        stage_d = '0;
        done_d  = 1'b1;
      end
      default: state_d = HOLD;
    endcase

    // Restart re-asserts every stage in one cycle; soft request wins over lock loss.
    if (state_q != HOLD && (soft_rst_i || !lock_s)) begin
      state_d     = HOLD;
      stage_d     = '1;
      done_d      = 1'b0;
      lock_cnt_d  = '0;
      dly_cnt_d   = '0;
      stage_idx_d = '0;
      hold_cnt_d  = soft_rst_i ? HOLD_MAX : '0;
    end
  end

  assign rst_stage_o = stage_q;
  assign done_o      = done_q;

`ifdef RESET_SEQ_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          timeout_q;

  always_comb begin
    wdog_cnt_d = '0;
    if (state_q == HOLD)
      wdog_cnt_d = (wdog_cnt_q == WDOG_MAX) ? wdog_cnt_q : wdog_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      if (wdog_cnt_d == WDOG_MAX) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; covers power-up, lock glitches,
// soft reset, async reset mid-release and (when RESET_SEQ_WDOG_EN is defined) the watchdog.
module tb_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       pll_locked_i;
  logic       soft_rst_i;
  logic [3:0] rst_stage_o;
  logic       done_o;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pll_locked_i (pll_locked_i),
    .soft_rst_i   (soft_rst_i),
    .rst_stage_o  (rst_stage_o),
    .done_o       (done_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected stage vector n edges after lock became valid at the PLL pin (power-up numbering).
  function automatic logic [3:0] exp_stage(input int n);
    if (n < 26)      return 4'b1111;
    else if (n < 42) return 4'b1110;
    else if (n < 58) return 4'b1100;
    else if (n < 74) return 4'b1000;
    else             return 4'b0000;
  endfunction

  task automatic edge_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_seq(input string tag, input int first, input int last);
    for (int n = first; n <= last; n++) begin
      edge_step();
      check($sformatf("%s_stage@%0d", tag, n), 32'(rst_stage_o), 32'(exp_stage(n)));
      check($sformatf("%s_done@%0d", tag, n), 32'(done_o), 32'(n >= 75));
      check($sformatf("%s_tmo@%0d", tag, n), 32'(timeout_o), 32'd0);
    end
  endtask

  task automatic do_reset(input logic lock);
    rst_i        = 1'b1;
    pll_locked_i = lock;
    soft_rst_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int k;
    rst_i        = 1'b1;
    pll_locked_i = 1'b1;
    soft_rst_i   = 1'b0;
    #1;
    check("rst_stage", 32'(rst_stage_o), 32'hF);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_tmo", 32'(timeout_o), 32'd0);

    // Power-up with lock tied high.
    do_reset(1'b1);
    run_seq("pwr", 1, 80);

    // One-cycle lock drop while in RUN.
    pll_locked_i = 1'b0;
    edge_step();
    pll_locked_i = 1'b1;
    edge_step();
    check("lock_n1_stage", 32'(rst_stage_o), 32'h0);
    check("lock_n1_done", 32'(done_o), 32'd1);
    run_seq("lock", 2, 76);

    // One-cycle soft reset while in RUN.
    soft_rst_i = 1'b1;
    edge_step();
    soft_rst_i = 1'b0;
    check("soft_stage", 32'(rst_stage_o), 32'hF);
    check("soft_done", 32'(done_o), 32'd0);
    k = 0;
    while (k < 100 && rst_stage_o[0]) begin
      edge_step();
      k++;
    end
    check("soft_fall_min", 32'(k >= 48), 32'd1);
    check("soft_fall_max", 32'(k <= 50), 32'd1);
    k = 0;
    while (k < 100 && !done_o) begin
      edge_step();
      k++;
    end
    check("soft_run_done", 32'(done_o), 32'd1);
    check("soft_run_stage", 32'(rst_stage_o), 32'h0);

    // Async reset in the middle of release.
    do_reset(1'b1);
    run_seq("mid", 1, 45);
    check("mid_pre", 32'(rst_stage_o), 32'hC);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_async_stage", 32'(rst_stage_o), 32'hF);
    check("mid_async_done", 32'(done_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_seq("rerun", 1, 80);

    // Lock pulses shorter than the filter never start release.
    do_reset(1'b0);
    for (int i = 0; i < 60; i++) begin
      pll_locked_i = ((i % 10) < 5);
      edge_step();
      check($sformatf("glitch_stage@%0d", i), 32'(rst_stage_o), 32'hF);
      check($sformatf("glitch_done@%0d", i), 32'(done_o), 32'd0);
    end

`ifdef RESET_SEQ_WDOG_EN
    do_reset(1'b0);
    for (int e = 1; e <= 1023; e++) edge_step();
    check("wdog_1023", 32'(timeout_o), 32'd0);
    edge_step();
    check("wdog_1024", 32'(timeout_o), 32'd1);
    pll_locked_i = 1'b1;
    repeat (90) edge_step();
    check("wdog_run_done", 32'(done_o), 32'd1);
    check("wdog_sticky", 32'(timeout_o), 32'd1);
`else
    do_reset(1'b0);
    repeat (1100) edge_step();
    check("nowdog_tmo", 32'(timeout_o), 32'd0);
    check("nowdog_stage", 32'(rst_stage_o), 32'hF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
